// File: rtl/hilo_sequencer_if.sv
// ---------------------------------------------------------------------------
// hilo_sequencer_if
//  Bundles every non-clock/reset signal of the HI/LO sequencer.
//  The master side is the pipeline plus the integer ALU result path; the
//  slave side is the sequencer itself.
//
//  Signals
//   start   master->slave  1   request, sampled only while the sequencer idles
//   op      master->slave  3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                              100 MTHI, 101 MTLO, 11x reserved
//   a       master->slave  32  rs operand
//   b       master->slave  32  rt operand
//   alu_hi  master->slave  32  ALU hi result
//   alu_lo  master->slave  32  ALU lo result
//   alu_a   slave->master  32  latched operand a towards the ALU
//   alu_b   slave->master  32  latched operand b towards the ALU
//   alu_op  slave->master  4   ALU opcode, 4'b0000 outside of a multiply
//   busy    slave->master  1   operation in flight, stalls the pipeline
//   done    slave->master  1   one-cycle pulse after a mult/div HI/LO write
//   hi      slave->master  32  architectural HI
//   lo      slave->master  32  architectural LO
// ---------------------------------------------------------------------------
interface hilo_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, alu_hi, alu_lo,
        input  alu_a, alu_b, alu_op, busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, alu_hi, alu_lo,
        output alu_a, alu_b, alu_op, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_sequencer.sv
// ---------------------------------------------------------------------------
// hilo_sequencer
//  Multi-cycle HI/LO controller for the integer ALU. Owns the architectural
//  HI/LO registers and executes MULT/MULTU (through the external ALU
//  multiply path), DIV/DIVU (32-step restoring divider) and MTHI/MTLO.
//  While a mult/div is in flight busy is high; a one-cycle done pulse
//  follows every mult/div HI/LO write.
//
//  Parameters
//   MUL_LAT  cycles the ALU multiply opcode is held before capture (1..15)
//
//  Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of hilo_sequencer_if (request, operands, ALU
//          handshake, busy/done, architectural hi/lo)
//
//  Configuration
//   HILO_DIV_EN  defined: divider datapath plus DIV and FIX states.
//                undefined: no divider logic; DIV/DIVU are ignored like
//                reserved opcodes.
//
//  Timing (E0 = edge that accepts start in IDLE)
//   MULT/MULTU : HI/LO written at E0+MUL_LAT, done high the cycle after.
//   DIV/DIVU   : 32 steps at E0+1..E0+32, HI/LO written at E0+33.
//   MTHI/MTLO  : written at E0, no busy, no done.
// ---------------------------------------------------------------------------
module hilo_sequencer #(
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    hilo_sequencer_if.slave bus
);

    localparam logic [2:0] OP_MULT   = 3'b000;
    localparam logic [2:0] OP_MULTU  = 3'b001;
    localparam logic [2:0] OP_MTHI   = 3'b100;
    localparam logic [2:0] OP_MTLO   = 3'b101;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_MULT  = 4'b0110;
    localparam logic [3:0] ALU_MULTU = 4'b0111;

    // count runs 0..MUL_LAT-1 while multiplying; capture happens on the edge
    // that sees the last value, which is edge E0+MUL_LAT.
    localparam logic [4:0] MUL_LAST  = 5'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_t;

    state_t      state_r;
    logic [4:0]  count_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [3:0]  alu_op_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

`ifdef HILO_DIV_EN
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;

    // Divider datapath: quot_r starts as the dividend magnitude and the
    // quotient bits shift in from the right as the dividend shifts out.
    logic [31:0] rem_r;
    logic [31:0] quot_r;
    logic [31:0] divisor_r;
    logic        neg_quot_r;
    logic        neg_rem_r;

    logic [32:0] div_shift_s;
    logic [32:0] div_trial_s;
    logic        div_fits_s;
    logic [31:0] quot_fixed_s;
    logic [31:0] rem_fixed_s;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // 32'h80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

    // One restoring step plus the final sign correction of quotient/remainder.
    always_comb begin
        div_shift_s  = {rem_r, quot_r[31]};
        // The remainder stays below the divisor, so the shifted value is
        // below twice the divisor and bit 32 of a 33-bit difference is a
        // reliable borrow. A zero divisor never borrows; it is patched in FIX.
        div_trial_s  = div_shift_s - {1'b0, divisor_r};
        div_fits_s   = ~div_trial_s[32];
        quot_fixed_s = neg_quot_r ? neg32(quot_r) : quot_r;
        rem_fixed_s  = neg_rem_r  ? neg32(rem_r)  : rem_r;
    end
`endif

    // Sequencer state, operand latches, divider registers and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            count_r    <= 5'd0;
            alu_a_r    <= 32'd0;
            alu_b_r    <= 32'd0;
            alu_op_r   <= ALU_NOP;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
`ifdef HILO_DIV_EN
            rem_r      <= 32'd0;
            quot_r     <= 32'd0;
            divisor_r  <= 32'd0;
            neg_quot_r <= 1'b0;
            neg_rem_r  <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse; only a HI/LO write raises it.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                alu_a_r  <= bus.a;
                                alu_b_r  <= bus.b;
                                alu_op_r <= (bus.op == OP_MULT) ? ALU_MULT : ALU_MULTU;
                                count_r  <= 5'd0;
                                busy_r   <= 1'b1;
                                state_r  <= ST_MUL;
                            end
`ifdef HILO_DIV_EN
                            OP_DIV: begin
                                quot_r     <= abs32(bus.a);
                                divisor_r  <= abs32(bus.b);
                                rem_r      <= 32'd0;
                                neg_quot_r <= bus.a[31] ^ bus.b[31];
                                neg_rem_r  <= bus.a[31];
                                count_r    <= 5'd0;
                                busy_r     <= 1'b1;
                                state_r    <= ST_DIV;
                            end
                            OP_DIVU: begin
                                quot_r     <= bus.a;
                                divisor_r  <= bus.b;
                                rem_r      <= 32'd0;
                                neg_quot_r <= 1'b0;
                                neg_rem_r  <= 1'b0;
                                count_r    <= 5'd0;
                                busy_r     <= 1'b1;
                                state_r    <= ST_DIV;
                            end
`endif
                            OP_MTHI: begin
                                hi_r <= bus.a;
                            end
                            OP_MTLO: begin
                                lo_r <= bus.a;
                            end
                            default: begin
                                // Reserved (and, without the divider, DIV/DIVU):
                                // no architectural effect.
                            end
                        endcase
                    end
                end

                ST_MUL: begin
                    if (count_r == MUL_LAST) begin
                        hi_r     <= bus.alu_hi;
                        lo_r     <= bus.alu_lo;
                        alu_op_r <= ALU_NOP;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        count_r  <= count_r + 5'd1;
                    end
                end

`ifdef HILO_DIV_EN
                ST_DIV: begin
                    rem_r   <= div_fits_s ? div_trial_s[31:0] : div_shift_s[31:0];
                    quot_r  <= {quot_r[30:0], div_fits_s};
                    count_r <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end

                ST_FIX: begin
                    // With a zero divisor the remainder register ends up
                    // holding the dividend magnitude, so after the sign fix
                    // hi already equals the original a; only lo is forced.
                    lo_r    <= (divisor_r == 32'd0) ? 32'hFFFF_FFFF : quot_fixed_s;
                    hi_r    <= rem_fixed_s;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
`endif

                default: begin
                    state_r  <= ST_IDLE;
                    count_r  <= 5'd0;
                    alu_op_r <= ALU_NOP;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_a  = alu_a_r;
    assign bus.alu_b  = alu_b_r;
    assign bus.alu_op = alu_op_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;

endmodule

// File: tb/tb_hilo_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hilo_sequencer
//  Self-checking bench for hilo_sequencer. Plays the pipeline and the ALU
//  multiply path, and predicts HI/LO from plain 64-bit arithmetic.
//  Divider scenarios are selected with HILO_DIV_EN, matching the design.
// ---------------------------------------------------------------------------
module tb_hilo_sequencer;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Reference view of the architectural registers.
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    hilo_sequencer_if ifc();

    hilo_sequencer #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // ALU multiply path: garbage whenever no multiply opcode is driven, so a
    // capture at the wrong moment shows up in HI/LO.
    always_comb begin
        logic [63:0] p;
        p = 64'hDEAD_BEEF_0BAD_F00D;
        if (ifc.alu_op == 4'b0110) begin
            p = 64'(longint'($signed(ifc.alu_a)) * longint'($signed(ifc.alu_b)));
        end else if (ifc.alu_op == 4'b0111) begin
            p = {32'd0, ifc.alu_a} * {32'd0, ifc.alu_b};
        end else begin
            p = 64'hDEAD_BEEF_0BAD_F00D;
        end
        ifc.alu_hi = p[63:32];
        ifc.alu_lo = p[31:0];
    end

    function automatic logic [63:0] ref_mult(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op == 3'b000) begin
            return 64'(longint'($signed(x)) * longint'($signed(y)));
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint q;
        longint r;
        if (y == 32'd0) begin
            return {x, 32'hFFFF_FFFF};
        end
        if (op == 3'b010) begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
        end else begin
            q = longint'({32'd0, x}) / longint'({32'd0, y});
            r = longint'({32'd0, x}) % longint'({32'd0, y});
        end
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one request, then observe `window` cycles after the accepting edge.
    task automatic run_op(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int window, output int busy_n, output int done_n, output int done_at,
                          output int mulop_n, output logic [3:0] mulop_v, output logic [63:0] ab_seen);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.op    = op_i;
        ifc.a     = a_i;
        ifc.b     = b_i;
        @(posedge clk);
        busy_n = 0; done_n = 0; done_at = -1; mulop_n = 0; mulop_v = 4'd0; ab_seen = 64'd0;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ifc.start = 1'b0;
                ifc.a     = $urandom;
                ifc.b     = $urandom;
                ifc.op    = 3'($urandom_range(0, 7));
                ab_seen   = {ifc.alu_a, ifc.alu_b};
            end
            if (ifc.busy === 1'b1) busy_n++;
            if (ifc.done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (ifc.alu_op !== 4'd0) begin
                mulop_n++;
                mulop_v = ifc.alu_op;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({ifc.hi, ifc.lo} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {ifc.hi, ifc.lo});
        else pass_cnt++;
        total_cnt++;
        if ({ifc.busy, ifc.done, ifc.alu_op} !== 6'd0) $display("FAIL reset_ctrl: busy/done/alu_op got %b want 0", {ifc.busy, ifc.done, ifc.alu_op});
        else pass_cnt++;
        total_cnt++;
        if ({ifc.alu_a, ifc.alu_b} !== 64'd0) $display("FAIL reset_alu_ab: got %h want 0", {ifc.alu_a, ifc.alu_b});
        else pass_cnt++;
        rst_n = 1'b1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
    endtask

    task automatic check_mult(input string nm, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int b_n, d_n, d_at, m_n;
        logic [3:0]  m_v;
        logic [63:0] ab, want;
        run_op(op, x, y, MUL_LAT + 3, b_n, d_n, d_at, m_n, m_v, ab);
        want = ref_mult(op, x, y);
        {exp_hi, exp_lo} = want;
        total_cnt++;
        if ({ifc.hi, ifc.lo} !== want) $display("FAIL %s_hilo: got %h want %h", nm, {ifc.hi, ifc.lo}, want);
        else pass_cnt++;
        total_cnt++;
        if (b_n !== MUL_LAT || d_n !== 1 || d_at !== MUL_LAT + 1)
            $display("FAIL %s_timing: busy %0d done %0d at %0d want busy %0d done 1 at %0d", nm, b_n, d_n, d_at, MUL_LAT, MUL_LAT + 1);
        else pass_cnt++;
        total_cnt++;
        if (m_n !== MUL_LAT || m_v !== {3'b011, op[0]})
            $display("FAIL %s_aluop: %0d cycles of %b want %0d cycles of %b", nm, m_n, m_v, MUL_LAT, {3'b011, op[0]});
        else pass_cnt++;
        total_cnt++;
        if (ab !== {x, y}) $display("FAIL %s_operands: got %h want %h", nm, ab, {x, y});
        else pass_cnt++;
    endtask

    task automatic test_mult();
        logic [31:0] x, y;
        check_mult("mult_neg3x7", 3'b000, 32'hFFFF_FFFD, 32'd7);
        check_mult("multu_max_x2", 3'b001, 32'hFFFF_FFFF, 32'd2);
        check_mult("mult_min_x_min", 3'b000, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 10; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                x = $urandom_range(0, 20);
                if ($urandom_range(0, 1) == 1) x = -x;
            end
            check_mult("mult_rand", 3'($urandom_range(0, 1)), x, y);
        end
    endtask

    task automatic test_mt_back_to_back();
        int busy_seen = 0;
        int done_seen = 0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = 3'b100; ifc.a = 32'd1234;
        @(negedge clk);
        if (ifc.busy === 1'b1) busy_seen++;
        ifc.op = 3'b101; ifc.a = 32'd5678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ifc.start = 1'b0;
            if (ifc.busy !== 1'b0) busy_seen++;
            if (ifc.done !== 1'b0) done_seen++;
        end
        exp_hi = 32'd1234;
        exp_lo = 32'd5678;
        total_cnt++;
        if ({ifc.hi, ifc.lo} !== {exp_hi, exp_lo}) $display("FAIL mt_b2b_hilo: got %h want %h", {ifc.hi, ifc.lo}, {exp_hi, exp_lo});
        else pass_cnt++;
        total_cnt++;
        if (busy_seen !== 0 || done_seen !== 0) $display("FAIL mt_b2b_ctrl: busy cycles %0d done cycles %0d want 0 and 0", busy_seen, done_seen);
        else pass_cnt++;
    endtask

    task automatic check_ignored(input string nm, input logic [2:0] op, input int window);
        int b_n, d_n, d_at, m_n;
        logic [3:0]  m_v;
        logic [63:0] ab;
        run_op(op, $urandom, $urandom, window, b_n, d_n, d_at, m_n, m_v, ab);
        total_cnt++;
        if ({ifc.hi, ifc.lo} !== {exp_hi, exp_lo}) $display("FAIL %s_hilo: got %h want %h", nm, {ifc.hi, ifc.lo}, {exp_hi, exp_lo});
        else pass_cnt++;
        total_cnt++;
        if (b_n !== 0 || d_n !== 0 || m_n !== 0) $display("FAIL %s_ctrl: busy %0d done %0d aluop %0d want 0 0 0", nm, b_n, d_n, m_n);
        else pass_cnt++;
    endtask

    task automatic test_reserved();
        check_ignored("reserved_110", 3'b110, 4);
        check_ignored("reserved_111", 3'b111, 4);
    endtask

`ifdef HILO_DIV_EN
    task automatic check_div(input string nm, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        int b_n, d_n, d_at, m_n;
        logic [3:0]  m_v;
        logic [63:0] ab, want;
        run_op(op, x, y, DIV_LAT + 3, b_n, d_n, d_at, m_n, m_v, ab);
        want = ref_div(op, x, y);
        {exp_hi, exp_lo} = want;
        total_cnt++;
        if ({ifc.hi, ifc.lo} !== want) $display("FAIL %s_hilo: got %h want %h", nm, {ifc.hi, ifc.lo}, want);
        else pass_cnt++;
        total_cnt++;
        if (b_n !== DIV_LAT || d_n !== 1 || d_at !== DIV_LAT + 1 || m_n !== 0)
            $display("FAIL %s_timing: busy %0d done %0d at %0d aluop %0d want %0d 1 %0d 0", nm, b_n, d_n, d_at, m_n, DIV_LAT, DIV_LAT + 1);
        else pass_cnt++;
    endtask

    task automatic test_div();
        logic [31:0] x, y;
        check_div("div_neg7_2", 3'b010, 32'hFFFF_FFF9, 32'd2);
        check_div("divu_100_7", 3'b011, 32'd100, 32'd7);
        check_div("div_by_zero", 3'b010, 32'd5, 32'd0);
        check_div("div_neg_by_zero", 3'b010, 32'hFFFF_FFF0, 32'd0);
        check_div("divu_by_zero", 3'b011, 32'hF000_0001, 32'd0);
        check_div("div_overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 1000)));
            check_div("div_rand", 3'($urandom_range(2, 3)), x, y);
        end
    endtask
`else
    task automatic test_div_disabled();
        check_ignored("div_disabled", 3'b010, DIV_LAT + 3);
        check_ignored("divu_disabled", 3'b011, DIV_LAT + 3);
    endtask
`endif

    task automatic test_start_while_busy();
        int b_n = 0;
        int d_n = 0;
        logic [63:0] want;
        want = ref_mult(3'b000, 32'h0001_2345, 32'hFFFF_FF00);
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = 3'b000; ifc.a = 32'h0001_2345; ifc.b = 32'hFFFF_FF00;
        @(posedge clk);
        for (int k = 1; k <= MUL_LAT + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ifc.start = 1'b1; ifc.op = 3'b100; ifc.a = 32'h5555_AAAA;
            end else if (k == 2) begin
                ifc.start = 1'b1; ifc.op = 3'b010; ifc.a = 32'd9; ifc.b = 32'd3;
            end else begin
                ifc.start = 1'b0;
            end
            if (ifc.busy === 1'b1) b_n++;
            if (ifc.done === 1'b1) d_n++;
        end
        {exp_hi, exp_lo} = want;
        total_cnt++;
        if ({ifc.hi, ifc.lo} !== want) $display("FAIL busy_ignore_hilo: got %h want %h", {ifc.hi, ifc.lo}, want);
        else pass_cnt++;
        total_cnt++;
        if (b_n !== MUL_LAT || d_n !== 1) $display("FAIL busy_ignore_ctrl: busy %0d done %0d want %0d 1", b_n, d_n, MUL_LAT);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int b_n = 0;
        int d_n = 0;
        logic [31:0] x1, y1, x2, y2;
        logic [63:0] want;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        want = ref_mult(3'b001, x2, y2);
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = 3'b000; ifc.a = x1; ifc.b = y1;
        @(posedge clk);
        for (int k = 1; k <= 2 * MUL_LAT + 4; k++) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) b_n++;
            if (ifc.done === 1'b1) d_n++;
            if (k == MUL_LAT + 1) begin
                total_cnt++;
                if ({ifc.done, ifc.hi, ifc.lo} !== {1'b1, ref_mult(3'b000, x1, y1)})
                    $display("FAIL b2b_first: done/hilo got %h want %h", {ifc.done, ifc.hi, ifc.lo}, {1'b1, ref_mult(3'b000, x1, y1)});
                else pass_cnt++;
                ifc.start = 1'b1; ifc.op = 3'b001; ifc.a = x2; ifc.b = y2;
            end else begin
                ifc.start = 1'b0;
            end
        end
        {exp_hi, exp_lo} = want;
        total_cnt++;
        if ({ifc.hi, ifc.lo} !== want) $display("FAIL b2b_second_hilo: got %h want %h", {ifc.hi, ifc.lo}, want);
        else pass_cnt++;
        total_cnt++;
        if (b_n !== 2 * MUL_LAT || d_n !== 2) $display("FAIL b2b_ctrl: busy %0d done %0d want %0d 2", b_n, d_n, 2 * MUL_LAT);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int b_n, d_n, d_at, m_n;
        logic [3:0]  m_v;
        logic [63:0] ab;
        run_op(3'b100, 32'hCAFE_0001, 32'd0, 1, b_n, d_n, d_at, m_n, m_v, ab);
        run_op(3'b101, 32'hCAFE_0002, 32'd0, 1, b_n, d_n, d_at, m_n, m_v, ab);
        @(negedge clk);
`ifdef HILO_DIV_EN
        ifc.start = 1'b1; ifc.op = 3'b010; ifc.a = 32'd1000; ifc.b = 32'd7;
`else
        ifc.start = 1'b1; ifc.op = 3'b000; ifc.a = 32'd1000; ifc.b = 32'd7;
`endif
        @(negedge clk);
        ifc.start = 1'b0;
        total_cnt++;
        if (ifc.busy !== 1'b1) $display("FAIL rst_mid_started: busy got %b want 1", ifc.busy);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        total_cnt++;
        if ({ifc.hi, ifc.lo} !== 64'd0) $display("FAIL rst_mid_hilo: got %h want 0", {ifc.hi, ifc.lo});
        else pass_cnt++;
        total_cnt++;
        if ({ifc.busy, ifc.done, ifc.alu_op} !== 6'd0) $display("FAIL rst_mid_ctrl: busy/done/alu_op got %b want 0", {ifc.busy, ifc.done, ifc.alu_op});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV_LAT + 2) @(negedge clk);
        total_cnt++;
        if ({ifc.busy, ifc.done, ifc.hi, ifc.lo} !== 66'd0) $display("FAIL rst_mid_after: busy/done/hilo got %h want 0", {ifc.busy, ifc.done, ifc.hi, ifc.lo});
        else pass_cnt++;
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.op    = 3'b000;
        ifc.a     = 32'd0;
        ifc.b     = 32'd0;
        test_reset();
        test_mult();
        test_mt_back_to_back();
        test_reserved();
`ifdef HILO_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
